// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: turns decoded keypresses into the one-cycle strobes used by
// the operand registers (newhex/hexcode, newop, eq, clr). It also holds the
// pending operator and runs a start/done handshake with the arithmetic unit.
// Ports:
//   clock, reset        system clock, synchronous active-low reset
//   key_valid/key_code  key from the decoder; held until key_ready accepts it
//   key_ready           high only in IDLE
//   newhex/hexcode      digit strobe and digit value
//   newop, eq, clr      operator / load-answer / clear strobes
//   op_sel              pending operator (00 add, 01 sub, 10 mul)
//   arith_start/done    arithmetic handshake; start is held high through CALC
//   err                 sticky timeout flag, cleared only by the clear key
//   digits              digits entered for the current operand
module calc_key_sequencer #(
  parameter int unsigned MAX_DIGITS    = 4,
  parameter int unsigned ARITH_TIMEOUT = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  output logic       key_ready,
  output logic       newhex,
  output logic [3:0] hexcode,
  output logic       newop,
  output logic       eq,
  output logic       clr,
  output logic [1:0] op_sel,
  output logic       arith_start,
  input  logic       arith_done,
  output logic       err,
  output logic [2:0] digits
);

  localparam int unsigned CNT_W = (ARITH_TIMEOUT > 1) ? $clog2(ARITH_TIMEOUT) : 1;

  localparam logic [4:0] K_ADD = 5'd16;
  localparam logic [4:0] K_MUL = 5'd18;
  localparam logic [4:0] K_EQ  = 5'd19;
  localparam logic [4:0] K_CLR = 5'd20;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_COMMIT, S_NEWOP} state_e;

  state_e           state_q, state_d;
  logic             key_ready_q, key_ready_d;
  logic             newhex_q, newhex_d;
  logic [3:0]       hexcode_q, hexcode_d;
  logic             newop_q, newop_d;
  logic             eq_q, eq_d;
  logic             clr_q, clr_d;
  logic [1:0]       op_sel_q, op_sel_d;
  logic             arith_start_q, arith_start_d;
  logic             err_q, err_d;
  logic [2:0]       digits_q, digits_d;
  logic             pend_valid_q, pend_valid_d;
  logic             entered_q, entered_d;
  logic             chained_q, chained_d;
  logic [1:0]       next_op_q, next_op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept;
  logic is_hex;
  logic is_op;

  assign accept = key_valid && key_ready_q;
  assign is_hex = !key_code[4];
  assign is_op  = (key_code >= K_ADD) && (key_code <= K_MUL);

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    newhex_d     = 1'b0;
    hexcode_d    = hexcode_q;
    newop_d      = 1'b0;
    eq_d         = 1'b0;
    clr_d        = 1'b0;
    op_sel_d     = op_sel_q;
    err_d        = err_q;
    digits_d     = digits_q;
    pend_valid_d = pend_valid_q;
    entered_d    = entered_q;
    chained_d    = chained_q;
    next_op_d    = next_op_q;
    cnt_d        = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (key_code == K_CLR) begin
            clr_d        = 1'b1;
            pend_valid_d = 1'b0;
            entered_d    = 1'b0;
            digits_d     = 3'd0;
            err_d        = 1'b0;
            op_sel_d     = 2'b00;
            chained_d    = 1'b0;
          end else if (!err_q) begin
            if (is_hex) begin
              if (digits_q < 3'(MAX_DIGITS)) begin
                newhex_d  = 1'b1;
                hexcode_d = key_code[3:0];
                digits_d  = digits_q + 3'd1;
                entered_d = 1'b1;
              end
            end else if (is_op) begin
              digits_d  = 3'd0;
              entered_d = 1'b0;
              // Operator after a complete operand: evaluate the old op first
              if (pend_valid_q && entered_q) begin
                state_d   = S_CALC;
                cnt_d     = '0;
                chained_d = 1'b1;
                next_op_d = key_code[1:0];
              end else begin
                newop_d      = 1'b1;
                op_sel_d     = key_code[1:0];
                pend_valid_d = 1'b1;
              end
            end else if (key_code == K_EQ) begin
              if (pend_valid_q) begin
                state_d   = S_CALC;
                cnt_d     = '0;
                chained_d = 1'b0;
              end
            end
          end
        end
      end

      S_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (arith_done) begin
          state_d = S_COMMIT;
          eq_d    = 1'b1;
        end else if (cnt_q == CNT_W'(ARITH_TIMEOUT - 1)) begin
          state_d      = S_IDLE;
          err_d        = 1'b1;
          pend_valid_d = 1'b0;
          chained_d    = 1'b0;
        end
      end

      S_COMMIT: begin
        digits_d  = 3'd0;
        entered_d = 1'b0;
        if (chained_q) begin
          state_d      = S_NEWOP;
          newop_d      = 1'b1;
          op_sel_d     = next_op_q;
          pend_valid_d = 1'b1;
        end else begin
          state_d      = S_IDLE;
          pend_valid_d = 1'b0;
        end
      end

      S_NEWOP: begin
        state_d   = S_IDLE;
        chained_d = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase

    // Handshake outputs follow the state being entered so they stay registered
    key_ready_d   = (state_d == S_IDLE);
    arith_start_d = (state_d == S_CALC);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      key_ready_q   <= 1'b0;
      newhex_q      <= 1'b0;
      hexcode_q     <= 4'd0;
      newop_q       <= 1'b0;
      eq_q          <= 1'b0;
      clr_q         <= 1'b0;
      op_sel_q      <= 2'b00;
      arith_start_q <= 1'b0;
      err_q         <= 1'b0;
      digits_q      <= 3'd0;
      pend_valid_q  <= 1'b0;
      entered_q     <= 1'b0;
      chained_q     <= 1'b0;
      next_op_q     <= 2'b00;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      key_ready_q   <= key_ready_d;
      newhex_q      <= newhex_d;
      hexcode_q     <= hexcode_d;
      newop_q       <= newop_d;
      eq_q          <= eq_d;
      clr_q         <= clr_d;
      op_sel_q      <= op_sel_d;
      arith_start_q <= arith_start_d;
      err_q         <= err_d;
      digits_q      <= digits_d;
      pend_valid_q  <= pend_valid_d;
      entered_q     <= entered_d;
      chained_q     <= chained_d;
      next_op_q     <= next_op_d;
      cnt_q         <= cnt_d;
    end
  end

  assign key_ready   = key_ready_q;
  assign newhex      = newhex_q;
  assign hexcode     = hexcode_q;
  assign newop       = newop_q;
  assign eq          = eq_q;
  assign clr         = clr_q;
  assign op_sel      = op_sel_q;
  assign arith_start = arith_start_q;
  assign err         = err_q;
  assign digits      = digits_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer: a table of single-key IDLE vectors,
// then hand-written sequences for the arithmetic handshake, timeout, key
// back-pressure and reset during CALC.
module tb_calc_key_sequencer;

  logic       clock;
  logic       reset;
  logic       key_valid;
  logic [4:0] key_code;
  logic       key_ready;
  logic       newhex;
  logic [3:0] hexcode;
  logic       newop;
  logic       eq;
  logic       clr;
  logic [1:0] op_sel;
  logic       arith_start;
  logic       arith_done;
  logic       err;
  logic [2:0] digits;

  int checks = 0;
  int errors = 0;

  calc_key_sequencer #(.MAX_DIGITS(4), .ARITH_TIMEOUT(64)) dut (
    .clock      (clock),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .newhex     (newhex),
    .hexcode    (hexcode),
    .newop      (newop),
    .eq         (eq),
    .clr        (clr),
    .op_sel     (op_sel),
    .arith_start(arith_start),
    .arith_done (arith_done),
    .err        (err),
    .digits     (digits)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  typedef struct {
    logic       vld;
    logic [4:0] code;
    logic       nh;
    logic [3:0] hc;
    logic       no;
    logic [1:0] os;
    logic       cl;
    logic [2:0] dg;
  } vec_t;

  vec_t vecs [13];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Presents one key for one edge; caller must know key_ready is high
  task automatic send_key(input logic [4:0] code);
    key_valid = 1'b1;
    key_code  = code;
    step();
    key_valid = 1'b0;
  endtask

  int  n;
  int  n_eq;
  int  n_hex;
  int  first_hex;
  logic will_accept;

  initial begin
    reset      = 1'b0;
    key_valid  = 1'b0;
    key_code   = 5'd0;
    arith_done = 1'b0;

    vecs[0]  = '{1'b1, 5'd1,  1'b1, 4'd1, 1'b0, 2'd0, 1'b0, 3'd1};
    vecs[1]  = '{1'b1, 5'd2,  1'b1, 4'd2, 1'b0, 2'd0, 1'b0, 3'd2};
    vecs[2]  = '{1'b1, 5'd3,  1'b1, 4'd3, 1'b0, 2'd0, 1'b0, 3'd3};
    vecs[3]  = '{1'b1, 5'd4,  1'b1, 4'd4, 1'b0, 2'd0, 1'b0, 3'd4};
    vecs[4]  = '{1'b1, 5'd5,  1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 3'd4};
    vecs[5]  = '{1'b1, 5'd21, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 3'd4};
    vecs[6]  = '{1'b0, 5'd0,  1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 3'd4};
    vecs[7]  = '{1'b1, 5'd19, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 3'd4};
    vecs[8]  = '{1'b1, 5'd20, 1'b0, 4'd0, 1'b0, 2'd0, 1'b1, 3'd0};
    vecs[9]  = '{1'b1, 5'd16, 1'b0, 4'd0, 1'b1, 2'd0, 1'b0, 3'd0};
    vecs[10] = '{1'b1, 5'd18, 1'b0, 4'd0, 1'b1, 2'd2, 1'b0, 3'd0};
    vecs[11] = '{1'b1, 5'd9,  1'b1, 4'd9, 1'b0, 2'd2, 1'b0, 3'd1};
    vecs[12] = '{1'b1, 5'd20, 1'b0, 4'd0, 1'b0, 2'd0, 1'b1, 3'd0};

    // Reset state
    step();
    step();
    chk("rst_key_ready", 32'(key_ready), 32'd0);
    chk("rst_strobes", 32'({newhex, newop, eq, clr, arith_start, err}), 32'd0);
    chk("rst_op_sel", 32'(op_sel), 32'd0);
    chk("rst_digits", 32'(digits), 32'd0);
    reset = 1'b1;
    step();
    chk("key_ready_after_rst", 32'(key_ready), 32'd1);

    // Single-key vectors in IDLE
    for (int i = 0; i < 13; i++) begin
      key_valid = vecs[i].vld;
      key_code  = vecs[i].code;
      step();
      key_valid = 1'b0;
      chk($sformatf("vec%0d_newhex", i), 32'(newhex), 32'(vecs[i].nh));
      if (vecs[i].nh) chk($sformatf("vec%0d_hexcode", i), 32'(hexcode), 32'(vecs[i].hc));
      chk($sformatf("vec%0d_newop", i), 32'(newop), 32'(vecs[i].no));
      chk($sformatf("vec%0d_op_sel", i), 32'(op_sel), 32'(vecs[i].os));
      chk($sformatf("vec%0d_clr", i), 32'(clr), 32'(vecs[i].cl));
      chk($sformatf("vec%0d_digits", i), 32'(digits), 32'(vecs[i].dg));
      chk($sformatf("vec%0d_eq_start", i), 32'({eq, arith_start}), 32'd0);
      chk($sformatf("vec%0d_key_ready", i), 32'(key_ready), 32'd1);
    end

    // 3 + 5 = with done one cycle after start
    send_key(5'd3);
    send_key(5'd16);
    chk("add_newop", 32'(newop), 32'd1);
    chk("add_op_sel", 32'(op_sel), 32'd0);
    send_key(5'd5);
    send_key(5'd19);
    chk("eq1_start", 32'(arith_start), 32'd1);
    chk("eq1_ready_low", 32'(key_ready), 32'd0);
    chk("eq1_no_eq_yet", 32'(eq), 32'd0);
    arith_done = 1'b1;
    step();
    arith_done = 1'b0;
    chk("eq1_eq", 32'(eq), 32'd1);
    chk("eq1_start_drop", 32'(arith_start), 32'd0);
    chk("eq1_ready_during_eq", 32'(key_ready), 32'd0);
    step();
    chk("eq1_eq_single", 32'(eq), 32'd0);
    chk("eq1_no_newop", 32'(newop), 32'd0);
    chk("eq1_ready_back", 32'(key_ready), 32'd1);
    chk("eq1_digits", 32'(digits), 32'd0);
    send_key(5'd19);
    chk("eq2_no_start", 32'({eq, arith_start}), 32'd0);
    step();
    chk("eq2_no_eq", 32'({eq, arith_start}), 32'd0);

    // 2 * 3 then sub: chained, done after 5 cycles
    send_key(5'd2);
    send_key(5'd18);
    chk("mul_newop", 32'(newop), 32'd1);
    chk("mul_op_sel", 32'(op_sel), 32'd2);
    send_key(5'd3);
    send_key(5'd17);
    chk("chain_no_early_newop", 32'(newop), 32'd0);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("chain_start_c%0d", c), 32'(arith_start), 32'd1);
      chk($sformatf("chain_op_sel_c%0d", c), 32'(op_sel), 32'd2);
      arith_done = (c == 4);
      step();
    end
    arith_done = 1'b0;
    chk("chain_start_drop", 32'(arith_start), 32'd0);
    chk("chain_eq", 32'(eq), 32'd1);
    chk("chain_no_newop_yet", 32'(newop), 32'd0);
    step();
    chk("chain_newop", 32'(newop), 32'd1);
    chk("chain_new_op_sel", 32'(op_sel), 32'd1);
    chk("chain_eq_gone", 32'(eq), 32'd0);
    chk("chain_ready_low", 32'(key_ready), 32'd0);
    step();
    chk("chain_newop_single", 32'(newop), 32'd0);
    chk("chain_ready_back", 32'(key_ready), 32'd1);

    // Timeout: pending sub, equals, done never arrives
    send_key(5'd19);
    n = 0;
    n_eq = 0;
    while (arith_start && n < 200) begin
      n++;
      step();
      if (eq) n_eq++;
    end
    chk("timeout_start_cycles", 32'(n), 32'd64);
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_no_eq", 32'(n_eq), 32'd0);
    chk("timeout_ready", 32'(key_ready), 32'd1);
    send_key(5'd6);
    chk("err_hex_ignored", 32'(newhex), 32'd0);
    chk("err_digits_hold", 32'(digits), 32'd0);
    send_key(5'd16);
    chk("err_op_ignored", 32'(newop), 32'd0);
    send_key(5'd20);
    chk("err_clr", 32'(clr), 32'd1);
    chk("err_cleared", 32'(err), 32'd0);
    chk("clr_op_sel", 32'(op_sel), 32'd0);

    // Key held during CALC is not accepted until IDLE
    send_key(5'd1);
    send_key(5'd16);
    send_key(5'd2);
    send_key(5'd19);
    key_valid = 1'b1;
    key_code  = 5'd7;
    n_hex = 0;
    n_eq = 0;
    first_hex = -1;
    for (int c = 0; c < 10; c++) begin
      arith_done  = (c == 1);
      will_accept = key_valid && key_ready;
      step();
      if (will_accept) key_valid = 1'b0;
      if (eq) n_eq++;
      if (newhex) begin
        n_hex++;
        if (first_hex < 0) first_hex = c;
        chk("held_hexcode", 32'(hexcode), 32'd7);
      end
    end
    arith_done = 1'b0;
    key_valid  = 1'b0;
    chk("held_hex_count", 32'(n_hex), 32'd1);
    chk("held_hex_cycle", 32'(first_hex), 32'd3);
    chk("held_eq_count", 32'(n_eq), 32'd1);
    chk("held_digits", 32'(digits), 32'd1);

    // Reset in the middle of CALC
    send_key(5'd16);
    send_key(5'd4);
    send_key(5'd19);
    step();
    chk("midrst_in_calc", 32'(arith_start), 32'd1);
    reset = 1'b0;
    step();
    chk("midrst_start", 32'(arith_start), 32'd0);
    chk("midrst_strobes", 32'({newhex, newop, eq, clr}), 32'd0);
    chk("midrst_op_sel", 32'(op_sel), 32'd0);
    chk("midrst_ready", 32'(key_ready), 32'd0);
    reset = 1'b1;
    arith_done = 1'b1;
    n_eq = 0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (eq) n_eq++;
      if (newop) n++;
    end
    arith_done = 1'b0;
    chk("midrst_no_eq", 32'(n_eq), 32'd0);
    chk("midrst_no_newop", 32'(n), 32'd0);
    chk("midrst_ready_back", 32'(key_ready), 32'd1);
    chk("midrst_no_start", 32'(arith_start), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
